// File: rtl/inst_fetch.sv
// IF stage: owns the PC and assembles each 32-bit instruction from four byte reads.
// Bytes are stored little-endian. A redirect from ID may arrive at any point of a fetch.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StLast, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        pend_q, pend_d;
  logic [1:0]  pidx_q, pidx_d;
  logic        redirect;

  // Only stall[0] concerns the fetch stage.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  assign redirect = branch_flag_i && (state_q != StIdle);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    idx_d      = idx_q;
    inst_buf_d = inst_buf_q;
    pend_d     = pend_q;
    pidx_d     = pidx_q;

    if (redirect) begin
      // The in-flight byte and any grant this cycle belong to the abandoned stream.
      pc_d    = branch_target_i;
      idx_d   = 3'd0;
      pend_d  = 1'b0;
      state_d = StFetch;
    end else begin
      if (pend_q) begin
        inst_buf_d[8*pidx_q +: 8] = mem_rdata_i;
        pend_d = 1'b0;
      end
      unique case (state_q)
        StIdle: state_d = StFetch;
        StFetch: begin
          if (mem_gnt_i) begin
            pend_d = 1'b1;
            pidx_d = idx_q[1:0];
            idx_d  = idx_q + 3'd1;
            if (idx_q == 3'd3) state_d = StLast;
          end
        end
        StLast: state_d = StDone;
        StDone: begin
          if (!stall[0]) begin
            pc_d    = pc_q + 32'd4;
            idx_d   = 3'd0;
            state_d = StFetch;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      idx_q      <= 3'd0;
      inst_buf_q <= 32'h0;
      pend_q     <= 1'b0;
      pidx_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      idx_q      <= idx_d;
      inst_buf_q <= inst_buf_d;
      pend_q     <= pend_d;
      pidx_q     <= pidx_d;
    end
  end

  assign mem_req_o  = (state_q == StFetch);
  assign mem_addr_o = (state_q == StFetch) ? pc_q + {29'd0, idx_q} : 32'h0;
  assign stallreq_o = (state_q == StFetch) || (state_q == StLast);
  assign inst_o     = (state_q == StDone) ? inst_buf_q : 32'h0;
  assign pc_o       = pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: per-cycle vector table plus redirect, wrap and reset sequences.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic [7:0]  mem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        stallreq_o;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:511];

  inst_fetch #(.RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rdata_i    (mem_rdata_i),
    .pc_o           (pc_o),
    .inst_o         (inst_o),
    .stallreq_o     (stallreq_o)
  );

  always #5 clk = ~clk;

  // Byte memory: data for a granted request appears one cycle later, junk otherwise.
  always @(posedge clk) begin
    if (mem_req_o && mem_gnt_i) mem_rdata_i <= mem[mem_addr_o[8:0]];
    else mem_rdata_i <= 8'hEE;
  end

  typedef struct {
    logic        gnt;
    logic        stall0;
    logic        req;
    logic [31:0] addr;
    logic        sr;
    logic [31:0] inst;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Entered at a negedge with the DUT in fetch at byte 0 of pc; ends on the done cycle.
  task automatic fetch_word(input string name, input logic [31:0] pc, input logic [31:0] inst);
    for (int i = 0; i < 4; i++) begin
      check({name, "_addr"}, {96'd0, mem_addr_o}, {96'd0, pc + 32'(i)});
      mem_gnt_i = 1'b1;
      tick();
    end
    check({name, "_last"}, {126'd0, mem_req_o, stallreq_o}, {126'd0, 2'b01});
    tick();
    check({name, "_done"}, {63'd0, stallreq_o, inst_o, pc_o}, {63'd0, 1'b0, inst, pc});
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'hA5;
    {mem[0], mem[1], mem[2], mem[3]} = {8'h13, 8'h00, 8'h50, 8'h00};
    {mem[4], mem[5], mem[6], mem[7]} = {8'h93, 8'h00, 8'h10, 8'h00};
    {mem[256], mem[257], mem[258], mem[259]} = {8'h37, 8'h12, 8'h00, 8'h00};
    {mem[508], mem[509], mem[510], mem[511]} = {8'h6f, 8'h00, 8'h00, 8'h00};

    //            gnt   st0   req   addr   sr    inst          pc
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 32'h0,        32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h1, 1'b1, 32'h0,        32'h0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h2, 1'b1, 32'h0,        32'h0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h3, 1'b1, 32'h0,        32'h0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0,        32'h0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h00500013, 32'h0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h00500013, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h00500013, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h00500013, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h00500013, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 32'h0,        32'h4};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h5, 1'b1, 32'h0,        32'h4};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h5, 1'b1, 32'h0,        32'h4};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h5, 1'b1, 32'h0,        32'h4};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 32'h5, 1'b1, 32'h0,        32'h4};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 32'h6, 1'b1, 32'h0,        32'h4};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 32'h7, 1'b1, 32'h0,        32'h4};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0,        32'h4};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h00100093, 32'h4};

    rst = 1'b1;
    stall = 6'd0;
    branch_flag_i = 1'b0;
    branch_target_i = 32'h0;
    mem_gnt_i = 1'b0;
    tick();
    check("reset_out", {30'd0, mem_req_o, mem_addr_o, stallreq_o, inst_o, pc_o}, 128'd0);
    tick();
    rst = 1'b0;

    // Reset, stream fetch, stall hold in done, then denied grants on byte 1.
    for (int i = 0; i < 20; i++) begin
      check($sformatf("row%0d", i), {30'd0, mem_req_o, mem_addr_o, stallreq_o, inst_o, pc_o},
            {30'd0, vecs[i].req, vecs[i].addr, vecs[i].sr, vecs[i].inst, vecs[i].pc});
      mem_gnt_i = vecs[i].gnt;
      stall[0]  = vecs[i].stall0;
      tick();
    end

    check("stall_hold", {64'd0, inst_o, pc_o}, {64'd0, 32'h00100093, 32'h4});
    // Redirect together with stall release: target wins over pc+4.
    stall[0] = 1'b0;
    branch_flag_i = 1'b1;
    branch_target_i = 32'h200;
    tick();
    branch_flag_i = 1'b0;
    check("redir_done", {64'd0, pc_o, mem_addr_o}, {64'd0, 32'h200, 32'h200});

    // Redirect while byte 2 is in flight and byte 3 is being granted.
    mem_gnt_i = 1'b1;
    tick();
    tick();
    tick();
    check("pre_redir_addr", {96'd0, mem_addr_o}, {96'd0, 32'h203});
    branch_flag_i = 1'b1;
    branch_target_i = 32'h100;
    tick();
    branch_flag_i = 1'b0;
    check("redir_mid", {94'd0, stallreq_o, pc_o, mem_req_o}, {94'd0, 1'b1, 32'h100, 1'b1});
    fetch_word("fetch100", 32'h100, 32'h00001237);

    // PC wraps mod 2^32 past the top of the address space.
    branch_flag_i = 1'b1;
    branch_target_i = 32'hFFFF_FFFC;
    tick();
    branch_flag_i = 1'b0;
    fetch_word("fetch_top", 32'hFFFF_FFFC, 32'h0000006f);
    tick();
    check("wrap", {64'd0, pc_o, mem_addr_o}, {64'd0, 32'h0, 32'h0});

    // Async reset in the middle of a fetch (idx=2).
    tick();
    tick();
    check("pre_rst_addr", {96'd0, mem_addr_o}, {96'd0, 32'h2});
    rst = 1'b1;
    #1;
    check("rst_mid", {30'd0, mem_req_o, mem_addr_o, stallreq_o, inst_o, pc_o}, 128'd0);
    tick();
    rst = 1'b0;
    check("post_rst_idle", {126'd0, mem_req_o, stallreq_o}, 128'd0);
    tick();
    fetch_word("refetch0", 32'h0, 32'h00500013);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
